// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose:
//   Bundles every signal exchanged between the hazard controller and the
//   5-stage datapath. The controller uses the master modport. The datapath
//   (or a testbench standing in for it) uses the slave modport.
//
// Handshake semantics:
//   ihit / dhit are single-cycle completion strobes from the memory side.
//   An access is outstanding while its request (em_dREN / em_dWEN for data,
//   the implicit fetch for instructions) is high and its hit is low. The cycle
//   in which the hit is high is the cycle the access completes. The controller
//   never waits a cycle after a hit; it reacts in that same cycle.
//
// Signals:
//   ihit, dhit         : fetch / data access complete this cycle
//   em_dREN, em_dWEN   : memory stage holds a load / store
//   em_branch_taken    : branch or jump resolved taken in memory stage
//   de_dREN, de_wsel   : execute stage holds a load, and its destination reg
//   fd_rs, fd_rt       : decode-stage source registers
//   mw_halt            : halt instruction has reached writeback
//   pc_en              : PC update enable
//   xx_enable/xx_flush : per inter-stage latch hold/bubble controls
//   halt               : sticky halt indication
//   stall_count        : saturating count of stalled (pc_en=0) cycles
//   state_dbg, cnt_dbg : controller state and load-use countdown, for debug
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             em_dREN;
    logic             em_dWEN;
    logic             em_branch_taken;
    logic             de_dREN;
    logic [4:0]       de_wsel;
    logic [4:0]       fd_rs;
    logic [4:0]       fd_rt;
    logic             mw_halt;

    logic             pc_en;
    logic             fd_enable;
    logic             fd_flush;
    logic             de_enable;
    logic             de_flush;
    logic             em_enable;
    logic             em_flush;
    logic             mw_enable;
    logic             mw_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_count;
    logic [1:0]       state_dbg;
    logic [2:0]       cnt_dbg;

    // Hazard controller side.
    modport master (
        input  ihit, dhit, em_dREN, em_dWEN, em_branch_taken,
               de_dREN, de_wsel, fd_rs, fd_rt, mw_halt,
        output pc_en, fd_enable, fd_flush, de_enable, de_flush,
               em_enable, em_flush, mw_enable, mw_flush,
               halt, stall_count, state_dbg, cnt_dbg
    );

    // Datapath side.
    modport slave (
        output ihit, dhit, em_dREN, em_dWEN, em_branch_taken,
               de_dREN, de_wsel, fd_rs, fd_rt, mw_halt,
        input  pc_en, fd_enable, fd_flush, de_enable, de_flush,
               em_enable, em_flush, mw_enable, mw_flush,
               halt, stall_count, state_dbg, cnt_dbg
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central stall/flush sequencer for the 5-stage pipeline. Every cycle it
//   decides, combinationally, whether the PC and each inter-stage latch
//   advance, hold or take a bubble. It also runs a multi-cycle load-use
//   stall countdown, latches halt, and counts stalled cycles.
//
// Parameters:
//   STALL_CYCLES : bubbles inserted per load-use hazard (1..7)
//   CNT_W        : width of stall_count
//
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous, active-high reset
//   bus : pipeline_hazard_ctrl_if.master (hazard inputs, stage controls,
//         halt, stall_count, debug state)
//
// Decision priority, highest first:
//   halted > mw_halt > memory busy > taken branch > load-use stall
//   > fetch miss > normal advance
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    pipeline_hazard_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Countdown load value on entry to a load-use stall. The entry cycle is
    // itself the first bubble, so the remaining count is STALL_CYCLES-1.
    localparam logic [2:0] STALL_LOAD   = 3'(STALL_CYCLES - 1);
    localparam logic       SINGLE_STALL = (STALL_CYCLES == 1);

    state_t           state, next_state;
    logic [2:0]       cnt, next_cnt;
    logic [CNT_W-1:0] stall_count;

    logic mem_busy;
    logic load_use;

    logic pc_en;
    logic fd_enable, fd_flush;
    logic de_enable, de_flush;
    logic em_enable, em_flush;
    logic mw_enable, mw_flush;

    assign mem_busy = (bus.em_dREN | bus.em_dWEN) & ~bus.dhit;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = bus.de_dREN & (bus.de_wsel != 5'd0) &
                      ((bus.de_wsel == bus.fd_rs) | (bus.de_wsel == bus.fd_rt));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and stage control decode
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pc_en      = 1'b0;
        fd_enable  = 1'b0;
        fd_flush   = 1'b0;
        de_enable  = 1'b0;
        de_flush   = 1'b0;
        em_enable  = 1'b0;
        em_flush   = 1'b0;
        mw_enable  = 1'b0;
        mw_flush   = 1'b0;

        if (RST) begin
            // Everything held at zero while reset is applied.
            next_state = ST_RUN;
            next_cnt   = 3'd0;
        end else if (state == ST_HALTED) begin
            // Frozen until reset.
            next_state = ST_HALTED;
        end else if (bus.mw_halt) begin
            next_state = ST_HALTED;
        end else if (mem_busy) begin
            // Full freeze: the countdown pauses so no bubble is lost or added.
            next_state = state;
            next_cnt   = cnt;
        end else if (bus.em_branch_taken) begin
            // Squash the three younger stages; the branch itself retires.
            pc_en      = 1'b1;
            fd_flush   = 1'b1;
            de_flush   = 1'b1;
            em_flush   = 1'b1;
            mw_enable  = 1'b1;
            next_state = ST_RUN;
            next_cnt   = 3'd0;
        end else if ((state == ST_STALL) || load_use) begin
            // Hold PC and decode, bubble into execute, let the load proceed.
            de_flush  = 1'b1;
            em_enable = 1'b1;
            mw_enable = 1'b1;
            if (state == ST_RUN) begin
                next_cnt   = STALL_LOAD;
                next_state = SINGLE_STALL ? ST_RUN : ST_STALL;
            end else begin
                next_cnt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    next_state = ST_RUN;
                end
            end
        end else if (!bus.ihit) begin
            // Fetch not done: bubble into decode, drain the rest.
            fd_flush  = 1'b1;
            de_enable = 1'b1;
            em_enable = 1'b1;
            mw_enable = 1'b1;
        end else begin
            pc_en     = 1'b1;
            fd_enable = 1'b1;
            de_enable = 1'b1;
            em_enable = 1'b1;
            mw_enable = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter. Halted cycles are not stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (!pc_en && (state != ST_HALTED) && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.pc_en       = pc_en;
    assign bus.fd_enable   = fd_enable;
    assign bus.fd_flush    = fd_flush;
    assign bus.de_enable   = de_enable;
    assign bus.de_flush    = de_flush;
    assign bus.em_enable   = em_enable;
    assign bus.em_flush    = em_flush;
    assign bus.mw_enable   = mw_enable;
    assign bus.mw_flush    = mw_flush;
    assign bus.halt        = (state == ST_HALTED) & ~RST;
    assign bus.stall_count = stall_count;
    assign bus.state_dbg   = state;
    assign bus.cnt_dbg     = cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl with STALL_CYCLES=2, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge. ctl packs the stage controls as
//   {pc_en, fd_enable, fd_flush, de_enable, de_flush,
//    em_enable, em_flush, mw_enable, mw_flush}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [8:0] V_ZERO   = 9'b0_00_00_00_00;
    localparam logic [8:0] V_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] V_STALL  = 9'b0_00_01_10_10;
    localparam logic [8:0] V_BRANCH = 9'b1_01_01_01_10;
    localparam logic [8:0] V_NOIHIT = 9'b0_01_10_10_10;

    logic clk;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .STALL_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [8:0] ctl;
    assign ctl = {bus.pc_en, bus.fd_enable, bus.fd_flush, bus.de_enable,
                  bus.de_flush, bus.em_enable, bus.em_flush, bus.mw_enable,
                  bus.mw_flush};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.ihit            = 1'b1;
        bus.dhit            = 1'b0;
        bus.em_dREN         = 1'b0;
        bus.em_dWEN         = 1'b0;
        bus.em_branch_taken = 1'b0;
        bus.de_dREN         = 1'b0;
        bus.de_wsel         = 5'd0;
        bus.fd_rs           = 5'd0;
        bus.fd_rt           = 5'd0;
        bus.mw_halt         = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] wsel, input logic [4:0] rs,
                                input logic [4:0] rt);
        bus.de_dREN = 1'b1;
        bus.de_wsel = wsel;
        bus.fd_rs   = rs;
        bus.fd_rt   = rt;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        set_load_use(5'd5, 5'd5, 5'd5);
        bus.em_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_ZERO) begin
            $display("FAIL reset_ctl: got %b want %b", ctl, V_ZERO); fails++;
        end
        checks++;
        if (bus.halt !== 1'b0 || bus.stall_count !== 4'd0 || bus.state_dbg !== 2'd0) begin
            $display("FAIL reset_state: halt %b cnt %0d st %0d want 0 0 0",
                     bus.halt, bus.stall_count, bus.state_dbg); fails++;
        end
        next_cycle();
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_normal();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== V_RUN || bus.stall_count !== 4'd0) begin
                $display("FAIL normal_%0d: ctl %b cnt %0d want %b 0",
                         i, ctl, bus.stall_count, V_RUN); fails++;
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        // rt match: exactly two bubbles.
        set_load_use(5'd5, 5'd3, 5'd5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== V_STALL || bus.stall_count !== 4'(i)) begin
                $display("FAIL load_use_bubble_%0d: ctl %b cnt %0d want %b %0d",
                         i, ctl, bus.stall_count, V_STALL, i); fails++;
            end
            next_cycle();
        end
        bus.de_dREN = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.stall_count !== 4'd2) begin
            $display("FAIL load_use_resume: ctl %b cnt %0d want %b 2",
                     ctl, bus.stall_count, V_RUN); fails++;
        end
        next_cycle();
        // Destination register 0 never hazards.
        set_load_use(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN) begin
            $display("FAIL load_use_r0: ctl %b want %b", ctl, V_RUN); fails++;
        end
        next_cycle();
        // rs match also stalls.
        set_load_use(5'd9, 5'd9, 5'd1);
        @(negedge clk);
        checks++;
        if (ctl !== V_STALL) begin
            $display("FAIL load_use_rs: ctl %b want %b", ctl, V_STALL); fails++;
        end
        next_cycle();
        drive_idle();
        next_cycle();
        // Load with no register match does not stall.
        set_load_use(5'd7, 5'd6, 5'd8);
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.stall_count !== 4'd4) begin
            $display("FAIL load_use_nomatch: ctl %b cnt %0d want %b 4",
                     ctl, bus.stall_count, V_RUN); fails++;
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_mem_busy();
        do_reset();
        bus.em_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== V_ZERO || bus.stall_count !== 4'(i)) begin
                $display("FAIL mem_busy_%0d: ctl %b cnt %0d want %b %0d",
                         i, ctl, bus.stall_count, V_ZERO, i); fails++;
            end
            next_cycle();
        end
        bus.dhit = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.stall_count !== 4'd3) begin
            $display("FAIL mem_busy_done: ctl %b cnt %0d want %b 3",
                     ctl, bus.stall_count, V_RUN); fails++;
        end
        next_cycle();
        drive_idle();
        // Store freeze in the middle of a load-use stall.
        set_load_use(5'd4, 5'd4, 5'd0);
        @(negedge clk);
        checks++;
        if (ctl !== V_STALL) begin
            $display("FAIL stall_mem_first: ctl %b want %b", ctl, V_STALL); fails++;
        end
        next_cycle();
        bus.em_dWEN = 1'b1;
        bus.dhit    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== V_ZERO || bus.cnt_dbg !== 3'd1) begin
                $display("FAIL stall_mem_freeze_%0d: ctl %b cnt %0d want %b 1",
                         i, ctl, bus.cnt_dbg, V_ZERO); fails++;
            end
            next_cycle();
        end
        bus.dhit    = 1'b1;
        bus.de_dREN = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_STALL) begin
            $display("FAIL stall_mem_second: ctl %b want %b", ctl, V_STALL); fails++;
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.stall_count !== 4'd8) begin
            $display("FAIL stall_mem_resume: ctl %b cnt %0d want %b 8",
                     ctl, bus.stall_count, V_RUN); fails++;
        end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use(5'd5, 5'd5, 5'd0);
        next_cycle();
        // First STALL cycle: branch aborts the stall.
        bus.de_dREN         = 1'b0;
        bus.em_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_BRANCH) begin
            $display("FAIL branch_in_stall: ctl %b want %b", ctl, V_BRANCH); fails++;
        end
        next_cycle();
        bus.em_branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.state_dbg !== 2'd0) begin
            $display("FAIL branch_resume: ctl %b st %0d want %b 0",
                     ctl, bus.state_dbg, V_RUN); fails++;
        end
        next_cycle();
        // Branch and load-use together: branch wins, no stall entered.
        set_load_use(5'd6, 5'd0, 5'd6);
        bus.em_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_BRANCH) begin
            $display("FAIL branch_vs_load_use: ctl %b want %b", ctl, V_BRANCH); fails++;
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN || bus.stall_count !== 4'd1) begin
            $display("FAIL branch_no_stall: ctl %b cnt %0d want %b 1",
                     ctl, bus.stall_count, V_RUN); fails++;
        end
        next_cycle();
        // Fetch miss.
        bus.ihit = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_NOIHIT) begin
            $display("FAIL fetch_miss: ctl %b want %b", ctl, V_NOIHIT); fails++;
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.stall_count !== 4'd2) begin
            $display("FAIL fetch_miss_count: cnt %0d want 2", bus.stall_count); fails++;
        end
        next_cycle();
    endtask

    task automatic test_halt();
        do_reset();
        bus.mw_halt = 1'b1;
        bus.em_dREN = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== V_ZERO || bus.halt !== 1'b0) begin
            $display("FAIL halt_entry: ctl %b halt %b want %b 0", ctl, bus.halt, V_ZERO); fails++;
        end
        next_cycle();
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            bus.em_branch_taken = (i == 1);
            @(negedge clk);
            checks++;
            if (ctl !== V_ZERO || bus.halt !== 1'b1 || bus.stall_count !== 4'd1) begin
                $display("FAIL halted_%0d: ctl %b halt %b cnt %0d want %b 1 1",
                         i, ctl, bus.halt, bus.stall_count, V_ZERO); fails++;
            end
            next_cycle();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.halt !== 1'b0 || bus.stall_count !== 4'd0 || ctl !== V_ZERO) begin
            $display("FAIL halt_reset: halt %b cnt %0d ctl %b want 0 0 %b",
                     bus.halt, bus.stall_count, ctl, V_ZERO); fails++;
        end
        next_cycle();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN) begin
            $display("FAIL halt_reset_run: ctl %b want %b", ctl, V_RUN); fails++;
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_load_use(5'd3, 5'd3, 5'd3);
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.state_dbg !== 2'd0 || bus.cnt_dbg !== 3'd0 || bus.stall_count !== 4'd0) begin
            $display("FAIL reset_mid_stall: st %0d cnt %0d sc %0d want 0 0 0",
                     bus.state_dbg, bus.cnt_dbg, bus.stall_count); fails++;
        end
        next_cycle();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== V_RUN) begin
            $display("FAIL reset_mid_stall_run: ctl %b want %b", ctl, V_RUN); fails++;
        end
        next_cycle();
    endtask

    task automatic test_saturate();
        do_reset();
        bus.ihit = 1'b0;
        for (int i = 0; i < 14; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (bus.stall_count !== 4'd14) begin
            $display("FAIL sat_14: cnt %0d want 14", bus.stall_count); fails++;
        end
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (bus.stall_count !== 4'd15 || ctl !== V_NOIHIT) begin
            $display("FAIL sat_15: cnt %0d ctl %b want 15 %b",
                     bus.stall_count, ctl, V_NOIHIT); fails++;
        end
        next_cycle();
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_normal();
        test_load_use();
        test_mem_busy();
        test_branch();
        test_halt();
        test_reset_mid_stall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
